// File: rtl/stream_fifo_pkg.sv
// Shared project constants for stream_fifo: read-mode encoding only.
package stream_fifo_pkg;

    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

endpackage

// File: rtl/stream_fifo_mem.sv
// fifo_mem: simple dual-port storage, synchronous write and asynchronous read.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately not reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with registered-read or first-word-fall-through
// output, occupancy count, threshold flags and sticky overflow/underflow.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned FWFT       = FWFT_OFF,
    parameter int unsigned AFULL_TH   = DEPTH - 2,
    parameter int unsigned AEMPTY_TH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and at least 4");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH - 1)) begin : g_bad_afull
        $error("stream_fifo: AFULL_TH must lie in 1..DEPTH-1");
    end
    if ((AEMPTY_TH < 1) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
        $error("stream_fifo: AEMPTY_TH must lie in 1..DEPTH-1");
    end

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

    // Flush swallows both requests; a write may use the slot freed by a same-cycle read.
    assign w_rd_acc  = rd_en && !w_empty && !flush;
    assign w_wr_acc  = wr_en && (!w_full || w_rd_acc) && !flush;
    assign w_ovf_set = wr_en && w_full && !w_rd_acc && !flush;
    assign w_unf_set = rd_en && w_empty && !flush;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .wr_data (din),
        .rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_wr_acc, w_rd_acc})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            r_overflow  <= w_ovf_set || (r_overflow  && !err_clr);
            r_underflow <= w_unf_set || (r_underflow && !err_clr);
        end
    end

    if (FWFT == FWFT_ON) begin : g_fwft
        assign dout  = w_rd_data;
        assign valid = !w_empty;
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] r_dout;
        logic                  r_valid;

        // dout holds its last value between reads; valid pulses once per read.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_dout  <= '0;
                r_valid <= 1'b0;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_dout <= w_rd_data;
                end
            end
        end

        assign dout  = r_dout;
        assign valid = r_valid;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign almost_full  = (r_count >= CNT_W'(AFULL_TH));
    assign almost_empty = (r_count <= CNT_W'(AEMPTY_TH));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: DEPTH=4 registered-read and FWFT instances
// driven in lockstep and compared against a queue-based occupancy model.
module tb_stream_fifo;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned AFULL_TH  = DEPTH - 2;
    localparam int unsigned AEMPTY_TH = 2;

    logic       clk = 1'b0;
    logic       rst_n, flush, wr_en, rd_en, err_clr;
    logic [7:0] din;

    logic [7:0] d0_dout, d1_dout;
    logic       d0_valid, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
    logic       d1_valid, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
    logic [2:0] d0_count, d1_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_dout0;
    logic       m_valid0, m_ovf, m_unf;

    always #5 clk = ~clk;

    stream_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(d0_dout), .valid(d0_valid), .full(d0_full),
        .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
        .count(d0_count), .overflow(d0_ovf), .underflow(d0_unf), .err_clr(err_clr)
    );

    stream_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(d1_dout), .valid(d1_valid), .full(d1_full),
        .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
        .count(d1_count), .overflow(d1_ovf), .underflow(d1_unf), .err_clr(err_clr)
    );

    typedef struct {
        logic       r, f, w, rd, ec;
        logic [7:0] d;
        logic [2:0] cnt;
        logic       full, empty, vld;
        logic [7:0] dout;
        logic       ovf, unf;
    } vec_t;

    function automatic vec_t mkv(int r, int f, int w, int rd, int ec, int d,
                                 int cnt, int fl, int em, int vl, int dout,
                                 int ovf, int unf);
        vec_t v;
        v.r = 1'(r); v.f = 1'(f); v.w = 1'(w); v.rd = 1'(rd); v.ec = 1'(ec);
        v.d = 8'(d); v.cnt = 3'(cnt); v.full = 1'(fl); v.empty = 1'(em);
        v.vld = 1'(vl); v.dout = 8'(dout); v.ovf = 1'(ovf); v.unf = 1'(unf);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge, evaluated with the pre-edge queue contents.
    task automatic model_edge();
        logic rd_ok, wr_ok, ovf_set, unf_set;
        if (!rst_n) begin
            q.delete();
            m_dout0 = 8'h00; m_valid0 = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            rd_ok   = !flush && rd_en && (q.size() > 0);
            wr_ok   = !flush && wr_en && ((q.size() < DEPTH) || rd_ok);
            ovf_set = !flush && wr_en && !wr_ok;
            unf_set = !flush && rd_en && (q.size() == 0);
            if (flush) begin
                q.delete();
                m_valid0 = 1'b0;
            end else begin
                m_valid0 = rd_ok;
                if (rd_ok) m_dout0 = q.pop_front();
                if (wr_ok) q.push_back(din);
            end
            m_ovf = ovf_set || (m_ovf && !err_clr);
            m_unf = unf_set || (m_unf && !err_clr);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        chk("count0", 32'(d0_count), 32'(sz));
        chk("count1", 32'(d1_count), 32'(sz));
        chk("full0",  32'(d0_full),  32'(sz == DEPTH));
        chk("full1",  32'(d1_full),  32'(sz == DEPTH));
        chk("empty0", 32'(d0_empty), 32'(sz == 0));
        chk("empty1", 32'(d1_empty), 32'(sz == 0));
        chk("afull0", 32'(d0_af),    32'(sz >= AFULL_TH));
        chk("afull1", 32'(d1_af),    32'(sz >= AFULL_TH));
        chk("aempty0",32'(d0_ae),    32'(sz <= AEMPTY_TH));
        chk("aempty1",32'(d1_ae),    32'(sz <= AEMPTY_TH));
        chk("ovf0",   32'(d0_ovf),   32'(m_ovf));
        chk("ovf1",   32'(d1_ovf),   32'(m_ovf));
        chk("unf0",   32'(d0_unf),   32'(m_unf));
        chk("unf1",   32'(d1_unf),   32'(m_unf));
        chk("valid0", 32'(d0_valid), 32'(m_valid0));
        chk("dout0",  32'(d0_dout),  32'(m_dout0));
        chk("valid1", 32'(d1_valid), 32'(sz > 0));
        if (sz > 0) chk("dout1", 32'(d1_dout), 32'(q[0]));
    endtask

    task automatic step(input logic r, input logic f, input logic w, input logic rd,
                        input logic ec, input logic [7:0] d);
        rst_n = r; flush = f; wr_en = w; rd_en = rd; err_clr = ec; din = d;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    vec_t tbl[15];

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = 8'h00;
        m_dout0 = 8'h00; m_valid0 = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // Fill, overflow, err_clr, read+write at full, drain, underflow (FWFT=0 view)
        tbl[0]  = mkv(0,0,0,0,0,'h00, 0,0,1,0,'h00,0,0);
        tbl[1]  = mkv(1,0,1,0,0,'h11, 1,0,0,0,'h00,0,0);
        tbl[2]  = mkv(1,0,1,0,0,'h22, 2,0,0,0,'h00,0,0);
        tbl[3]  = mkv(1,0,1,0,0,'h33, 3,0,0,0,'h00,0,0);
        tbl[4]  = mkv(1,0,1,0,0,'h44, 4,1,0,0,'h00,0,0);
        tbl[5]  = mkv(1,0,1,0,0,'h55, 4,1,0,0,'h00,1,0);
        tbl[6]  = mkv(1,0,0,0,1,'h00, 4,1,0,0,'h00,0,0);
        tbl[7]  = mkv(1,0,1,1,0,'h66, 4,1,0,1,'h11,0,0);
        tbl[8]  = mkv(1,0,0,1,0,'h00, 3,0,0,1,'h22,0,0);
        tbl[9]  = mkv(1,0,0,1,0,'h00, 2,0,0,1,'h33,0,0);
        tbl[10] = mkv(1,0,0,1,0,'h00, 1,0,0,1,'h44,0,0);
        tbl[11] = mkv(1,0,0,1,0,'h00, 0,0,1,1,'h66,0,0);
        tbl[12] = mkv(1,0,0,0,0,'h00, 0,0,1,0,'h66,0,0);
        tbl[13] = mkv(1,0,0,1,0,'h00, 0,0,1,0,'h66,0,1);
        tbl[14] = mkv(1,0,0,0,1,'h00, 0,0,1,0,'h66,0,0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].w, tbl[i].rd, tbl[i].ec, tbl[i].d);
            chk($sformatf("vec%0d.count", i), 32'(d0_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.full",  i), 32'(d0_full),  32'(tbl[i].full));
            chk($sformatf("vec%0d.empty", i), 32'(d0_empty), 32'(tbl[i].empty));
            chk($sformatf("vec%0d.valid", i), 32'(d0_valid), 32'(tbl[i].vld));
            chk($sformatf("vec%0d.dout",  i), 32'(d0_dout),  32'(tbl[i].dout));
            chk($sformatf("vec%0d.ovf",   i), 32'(d0_ovf),   32'(tbl[i].ovf));
            chk($sformatf("vec%0d.unf",   i), 32'(d0_unf),   32'(tbl[i].unf));
        end

        // FWFT: a single word becomes visible the cycle after its write
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
        chk("fwft.valid", 32'(d1_valid), 32'd1);
        chk("fwft.dout",  32'(d1_dout),  32'hA5);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft.empty", 32'(d1_empty), 32'd1);
        chk("fwft.valid_after_rd", 32'(d1_valid), 32'd0);

        // Flush with a pending write, then underflow with dout retained
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03);
        chk("flush.pre_dout", 32'(d0_dout), 32'h01);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
        chk("flush.pre_count", 32'(d0_count), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05);
        chk("flush.count", 32'(d0_count), 32'd0);
        chk("flush.ovf",   32'(d0_ovf),   32'd0);
        chk("flush.valid", 32'(d0_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("flush.unf",   32'(d0_unf),   32'd1);
        chk("flush.dout",  32'(d0_dout),  32'h01);

        // Reset mid-stream with a read in flight
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h88);
        chk("rst.pre_count", 32'(d0_count), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("rst.count", 32'(d0_count), 32'd0);
        chk("rst.dout",  32'(d0_dout),  32'd0);
        chk("rst.valid", 32'(d0_valid), 32'd0);
        chk("rst.empty", 32'(d0_empty), 32'd1);
        chk("rst.aempty",32'(d0_ae),    32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("rst.readback", 32'(d0_dout), 32'h99);
        chk("rst.readback_valid", 32'(d0_valid), 32'd1);

        // Randomized traffic with alternating fill/drain bias
        for (int c = 0; c < 2000; c++) begin
            int wp;
            logic r, f, w, rd, ec;
            wp = ((c / 100) % 2 == 0) ? 75 : 25;
            r  = ($urandom_range(0, 299) != 0);
            f  = ($urandom_range(0, 59) == 0);
            w  = ($urandom_range(0, 99) < wp);
            rd = ($urandom_range(0, 99) < (100 - wp));
            ec = ($urandom_range(0, 29) == 0);
            step(r, f, w, rd, ec, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
